// File: rtl/raster_pkg.sv
// Shared definitions for the raster command path: command codes, queue entry
// layout and scheduler state encodings.
package raster_pkg;

  localparam logic [1:0] CMD_NOP   = 2'b00;
  localparam logic [1:0] CMD_PIXEL = 2'b01;
  localparam logic [1:0] CMD_LINE  = 2'b10;
  localparam logic [1:0] CMD_RECT  = 2'b11;

  localparam int COORD_W = 3;
  localparam int ENTRY_W = 20;

  typedef struct packed {
    logic [1:0]         cmd;
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y1;
    logic [COORD_W-1:0] x2;
    logic [COORD_W-1:0] y2;
    logic [COORD_W-1:0] w;
    logic [COORD_W-1:0] h;
  } raster_entry_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } sched_state_e;

endpackage

// File: rtl/raster_cmd_scheduler_if.sv
// Command bus (front-end -> scheduler) and issue bus (scheduler -> rasterizer).
// master = host/rasterizer side, slave = scheduler.
interface raster_cmd_scheduler_if;
  import raster_pkg::*;

  logic               in_valid;
  logic [1:0]         in_cmd;
  logic [COORD_W-1:0] in_x1, in_y1, in_x2, in_y2, in_width, in_height;
  logic               rast_busy;
  logic               rast_done;
  logic               out_start;
  logic [1:0]         out_cmd;
  logic [COORD_W-1:0] out_x1, out_y1, out_x2, out_y2, out_width, out_height;

  modport master (
    output in_valid, in_cmd, in_x1, in_y1, in_x2, in_y2, in_width, in_height,
    output rast_busy, rast_done,
    input  out_start, out_cmd, out_x1, out_y1, out_x2, out_y2, out_width, out_height
  );

  modport slave (
    input  in_valid, in_cmd, in_x1, in_y1, in_x2, in_y2, in_width, in_height,
    input  rast_busy, rast_done,
    output out_start, out_cmd, out_x1, out_y1, out_x2, out_y2, out_width, out_height
  );

endinterface

// File: rtl/raster_cmd_fifo.sv
// Synchronous FIFO for queued draw commands. A push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle; otherwise drop fires.
module raster_cmd_fifo
  import raster_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic               pop,
  output logic [ENTRY_W-1:0] rdata,
  output logic               full,
  output logic               empty,
  output logic               drop,
  output logic [PTR_W:0]     count
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     count_q, count_d;
  logic               do_push, do_pop;

  assign empty  = (count_q == '0);
  assign full   = (count_q == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) mem_q <= mem_d;

endmodule

// File: rtl/raster_cmd_scheduler.sv
// Queues draw commands from the front-end and issues them one at a time to the
// rasterizer over start/done, with sticky overflow and hang detection.
module raster_cmd_scheduler
  import raster_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  raster_cmd_scheduler_if.slave  bus,
  input  logic                   err_clr,
  output logic [CNT_W-1:0]       q_count,
  output logic                   idle,
  output logic                   overflow,
  output logic                   timeout_err
);

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  sched_state_e       state_q, state_d;
  logic [7:0]         timer_q, timer_d;
  raster_entry_t      out_q, out_d, in_entry, head;
  logic               out_start_q, out_start_d;
  logic               overflow_q, overflow_d;
  logic               timeout_q, timeout_d;
  logic               rst_done_q;
  logic               push_req, pop, fifo_full, fifo_empty, fifo_drop;
  logic [ENTRY_W-1:0] fifo_rdata;

  assign in_entry = {bus.in_cmd, bus.in_x1, bus.in_y1, bus.in_x2, bus.in_y2,
                     bus.in_width, bus.in_height};
  assign head     = fifo_rdata;
  assign push_req = bus.in_valid & (bus.in_cmd != CMD_NOP);
  // rast_busy only gates issue from IDLE; WAIT ignores it.
  assign pop      = (state_q == S_IDLE) & ~fifo_empty & ~bus.rast_busy;

  raster_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_req),
    .wdata (in_entry),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .drop  (fifo_drop),
    .count (q_count)
  );

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    out_d       = out_q;
    out_start_d = 1'b0;
    // A new error in the clearing cycle keeps the flag set.
    overflow_d  = (overflow_q & ~err_clr) | fifo_drop;
    timeout_d   = timeout_q & ~err_clr;
    unique case (state_q)
      S_IDLE: begin
        if (pop) begin
          out_d       = head;
          out_start_d = 1'b1;
          timer_d     = '0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.rast_done) begin
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + 8'd1;
          if (timer_d == TIMEOUT_C) begin
            timeout_d = 1'b1;
            state_d   = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      out_q       <= '0;
      out_start_q <= 1'b0;
      overflow_q  <= 1'b0;
      timeout_q   <= 1'b0;
      rst_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      out_q       <= out_d;
      out_start_q <= out_start_d;
      overflow_q  <= overflow_d;
      timeout_q   <= timeout_d;
      rst_done_q  <= 1'b1;
    end
  end

  assign idle           = rst_done_q & fifo_empty & (state_q == S_IDLE);
  assign overflow       = overflow_q;
  assign timeout_err    = timeout_q;
  assign bus.out_start  = out_start_q;
  assign bus.out_cmd    = out_q.cmd;
  assign bus.out_x1     = out_q.x1;
  assign bus.out_y1     = out_q.y1;
  assign bus.out_x2     = out_q.x2;
  assign bus.out_y2     = out_q.y2;
  assign bus.out_width  = out_q.w;
  assign bus.out_height = out_q.h;

endmodule

// File: tb/tb_raster_cmd_scheduler.sv
// Directed bench: expected issues are queued when commands are driven and
// compared in order whenever the scheduler pulses out_start.
module tb_raster_cmd_scheduler;
  import raster_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       err_clr;
  logic [2:0] q_count;
  logic       idle, overflow, timeout_err;
  int         checks = 0;
  int         failures = 0;
  logic [19:0] expq[$];

  raster_cmd_scheduler_if bus();

  raster_cmd_scheduler #(.DEPTH(4), .TIMEOUT(255)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .err_clr     (err_clr),
    .q_count     (q_count),
    .idle        (idle),
    .overflow    (overflow),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; single-cycle strobes drop here.
  task automatic tick();
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.rast_done = 1'b0;
    err_clr       = 1'b0;
  endtask

  task automatic push(input logic [1:0] c, input logic [2:0] x1, y1, x2, y2, w, h,
                      input bit accepted);
    bus.in_valid  = 1'b1;
    bus.in_cmd    = c;
    bus.in_x1     = x1;
    bus.in_y1     = y1;
    bus.in_x2     = x2;
    bus.in_y2     = y2;
    bus.in_width  = w;
    bus.in_height = h;
    if (accepted) expq.push_back({c, x1, y1, x2, y2, w, h});
  endtask

  // Call just after a rising edge; returns at the negedge of the out_start cycle.
  task automatic wait_start(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.out_start !== 1'b1 && n < 300) begin
      tick();
      @(negedge clk);
      n++;
    end
    check(tag, 32'(bus.out_start), 32'd1);
  endtask

  task automatic done_pulse();
    tick();
    bus.rast_done = 1'b1;
    tick();
  endtask

  // Scoreboard: every out_start must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.out_start === 1'b1) begin
      check("issue_expected", 32'(expq.size() != 0), 32'd1);
      if (expq.size() != 0) begin
        logic [19:0] e;
        e = expq.pop_front();
        check("issue_entry", 32'({bus.out_cmd, bus.out_x1, bus.out_y1, bus.out_x2,
                                  bus.out_y2, bus.out_width, bus.out_height}), 32'(e));
      end
    end
  end

  initial begin
    int k;
    rst_n = 1'b0; err_clr = 1'b0;
    bus.in_valid = 1'b0; bus.in_cmd = '0;
    bus.in_x1 = '0; bus.in_y1 = '0; bus.in_x2 = '0; bus.in_y2 = '0;
    bus.in_width = '0; bus.in_height = '0;
    bus.rast_busy = 1'b0; bus.rast_done = 1'b0;
    tick(); tick();
    @(negedge clk);
    check("rst_out_start", 32'(bus.out_start), 0);
    check("rst_q_count",   32'(q_count), 0);
    check("rst_idle",      32'(idle), 0);
    check("rst_flags",     32'({overflow, timeout_err}), 0);
    check("rst_out_cmd",   32'(bus.out_cmd), 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_release", 32'(idle), 0);
    tick();
    @(negedge clk);
    check("idle_after", 32'(idle), 1);

    // 1: single LINE, latency and idle
    tick();
    push(CMD_LINE, 3'd1, 3'd2, 3'd5, 3'd6, 3'd0, 3'd0, 1'b1);
    @(negedge clk);
    check("t1_c0_q", 32'(q_count), 0);
    check("t1_c0_idle", 32'(idle), 1);
    tick();
    @(negedge clk);
    check("t1_c1_q", 32'(q_count), 1);
    check("t1_c1_start", 32'(bus.out_start), 0);
    check("t1_c1_idle", 32'(idle), 0);
    tick();
    @(negedge clk);
    check("t1_c2_start", 32'(bus.out_start), 1);
    check("t1_c2_idle", 32'(idle), 0);
    tick(); tick();
    @(negedge clk);
    check("t1_wait_idle", 32'(idle), 0);
    check("t1_hold_x2", 32'(bus.out_x2), 5);
    tick();
    bus.rast_done = 1'b1;
    tick();
    @(negedge clk);
    check("t1_done_idle", 32'(idle), 1);

    // 2: overflow on fifth push while rasterizer busy
    tick();
    bus.rast_busy = 1'b1;
    push(CMD_PIXEL, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 1'b1); tick();
    push(CMD_LINE,  3'd0, 3'd7, 3'd7, 3'd0, 3'd0, 3'd0, 1'b1); tick();
    push(CMD_RECT,  3'd2, 3'd3, 3'd0, 3'd0, 3'd4, 3'd5, 1'b1); tick();
    push(CMD_PIXEL, 3'd6, 3'd5, 3'd0, 3'd0, 3'd0, 3'd0, 1'b1); tick();
    push(CMD_LINE,  3'd7, 3'd7, 3'd1, 3'd1, 3'd0, 3'd0, 1'b0); tick();
    @(negedge clk);
    check("t2_q_full", 32'(q_count), 4);
    check("t2_overflow", 32'(overflow), 1);
    tick();
    bus.rast_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_start("t2_start");
      done_pulse();
    end
    @(negedge clk);
    check("t2_drained", 32'(q_count), 0);
    check("t2_sb_empty", 32'(expq.size()), 0);
    tick();
    err_clr = 1'b1;
    tick();
    @(negedge clk);
    check("t2_ovf_clr", 32'(overflow), 0);

    // 3: push into full queue on the same cycle as an issue pop
    tick();
    bus.rast_busy = 1'b1;
    push(CMD_RECT,  3'd1, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 1'b1); tick();
    push(CMD_LINE,  3'd2, 3'd0, 3'd3, 3'd4, 3'd0, 3'd0, 1'b1); tick();
    push(CMD_PIXEL, 3'd3, 3'd3, 3'd0, 3'd0, 3'd0, 3'd0, 1'b1); tick();
    push(CMD_RECT,  3'd4, 3'd4, 3'd0, 3'd0, 3'd2, 3'd2, 1'b1); tick();
    bus.rast_busy = 1'b0;
    push(CMD_LINE,  3'd5, 3'd6, 3'd7, 3'd1, 3'd0, 3'd0, 1'b1);
    tick();
    @(negedge clk);
    check("t3_q_count", 32'(q_count), 4);
    check("t3_overflow", 32'(overflow), 0);
    check("t3_start", 32'(bus.out_start), 1);
    done_pulse();
    for (int i = 0; i < 4; i++) begin
      wait_start("t3_start_n");
      done_pulse();
    end
    @(negedge clk);
    check("t3_sb_empty", 32'(expq.size()), 0);

    // 4: withheld rast_done -> timeout, next entry still issues
    tick();
    push(CMD_RECT, 3'd7, 3'd6, 3'd0, 3'd0, 3'd5, 3'd4, 1'b1); tick();
    push(CMD_LINE, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd0, 1'b1); tick();
    wait_start("t4_start_a");
    k = 0;
    while (timeout_err !== 1'b1 && k < 400) begin
      tick();
      @(negedge clk);
      k++;
    end
    check("t4_timeout_cycles", 32'(k), 255);
    check("t4_timeout_err", 32'(timeout_err), 1);
    wait_start("t4_start_b");
    done_pulse();
    err_clr = 1'b1;
    tick();
    @(negedge clk);
    check("t4_err_clr", 32'(timeout_err), 0);

    // 5: NO_OP strobes never enter the queue
    tick();
    bus.rast_busy = 1'b1;
    push(CMD_NOP, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 1'b0); tick();
    @(negedge clk);
    check("t5_nop_q", 32'(q_count), 0);
    tick();
    push(CMD_RECT, 3'd0, 3'd0, 3'd0, 3'd0, 3'd3, 3'd3, 1'b1); tick();
    push(CMD_NOP,  3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 1'b0); tick();
    push(CMD_NOP,  3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 1'b0); tick();
    @(negedge clk);
    check("t5_rect_q", 32'(q_count), 1);
    check("t5_ovf", 32'(overflow), 0);
    tick();
    bus.rast_busy = 1'b0;
    wait_start("t5_start");
    done_pulse();
    @(negedge clk);
    check("t5_q_empty", 32'(q_count), 0);
    check("t5_sb_empty", 32'(expq.size()), 0);

    // 6: reset in WAIT with three entries queued
    tick();
    bus.rast_busy = 1'b1;
    push(CMD_LINE,  3'd1, 3'd1, 3'd2, 3'd2, 3'd0, 3'd0, 1'b1); tick();
    push(CMD_RECT,  3'd2, 3'd2, 3'd0, 3'd0, 3'd3, 3'd3, 1'b1); tick();
    push(CMD_PIXEL, 3'd4, 3'd4, 3'd0, 3'd0, 3'd0, 3'd0, 1'b1); tick();
    push(CMD_LINE,  3'd6, 3'd6, 3'd0, 3'd0, 3'd0, 3'd0, 1'b1); tick();
    bus.rast_busy = 1'b0;
    wait_start("t6_start");
    tick();
    @(negedge clk);
    check("t6_pre_q", 32'(q_count), 3);
    #1;
    rst_n = 1'b0;
    expq.delete();
    #1;
    check("t6_rst_start", 32'(bus.out_start), 0);
    check("t6_rst_q", 32'(q_count), 0);
    check("t6_rst_out", 32'({bus.out_cmd, bus.out_x1, bus.out_y1, bus.out_x2}), 0);
    check("t6_rst_flags", 32'({idle, overflow, timeout_err}), 0);
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    @(negedge clk);
    check("t6_post_q", 32'(q_count), 0);
    check("t6_post_idle", 32'(idle), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
